zynet_axil_regs: RTL and testbench

- AXI4-Lite slave register file for zyNet. The host/testbench configures and controls the network through it.
- Decodes host writes into one-cycle weight/bias load strobes, plus layer/neuron select and soft-reset levels for the layer array.
- Captures the final classification and the final-layer neuron outputs, and raises intr to the host.
- Sits between the AXI-Lite interface and the zyNet core.

---
 rtl/zynet_axil_regs_pkg.sv | 28 ++
 rtl/zynet_out_fifo.sv | 61 ++++++
 rtl/zynet_axil_regs.sv | 205 ++++++++++++++++++++
 tb/tb_zynet_axil_regs.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zynet_axil_regs_pkg.sv
// Shared definitions for the zyNet AXI4-Lite register file:
// register byte offsets, status bit positions, response code, FSM states.
package zynet_axil_regs_pkg;

  localparam logic [4:0] REG_WEIGHT  = 5'd0;
  localparam logic [4:0] REG_BIAS    = 5'd4;
  localparam logic [4:0] REG_RESULT  = 5'd8;
  localparam logic [4:0] REG_LAYER   = 5'd12;
  localparam logic [4:0] REG_NEURON  = 5'd16;
  localparam logic [4:0] REG_NOUT    = 5'd20;
  localparam logic [4:0] REG_STATUS  = 5'd24;
  localparam logic [4:0] REG_SOFTRST = 5'd28;

  localparam int STAT_INTR    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_CNT_LSB = 4;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

  // Byte address -> word-aligned register offset (sub-word bits dropped).
  function automatic logic [4:0] word_offset(input logic [4:0] addr);
    return {addr[4:2], 2'b00};
  endfunction

endpackage

// File: rtl/zynet_out_fifo.sv
// Synchronous FIFO holding final-layer neuron outputs for host readback.
// Head entry is presented combinationally so a read can capture it on
// the same edge that pops it. clr empties the FIFO synchronously.
module zynet_out_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 10
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           empty,
  output logic                           full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only taken when a pop frees a slot that cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array: written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking with wrap at DEPTH (not a power of two).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/zynet_axil_regs.sv
// zyNet AXI4-Lite register file: weight/bias load strobes, layer/neuron
// select, soft reset, result capture with interrupt, and optional
// neuron-output readback buffer enabled by ZYNET_OUT_READBACK_EN.
module zynet_axil_regs
  import zynet_axil_regs_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH         = 16,
  parameter int NUM_OUT            = 10
) (
  input  logic                            s_axi_aclk,
  input  logic                            s_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [DATA_WIDTH-1:0]           weight_value,
  output logic                            weight_valid,
  output logic [DATA_WIDTH-1:0]           bias_value,
  output logic                            bias_valid,
  output logic [31:0]                     layer_number,
  output logic [31:0]                     neuron_number,
  output logic                            soft_reset,
  input  logic [31:0]                     result_data,
  input  logic                            result_valid,
  input  logic [DATA_WIDTH-1:0]           nout_data,
  input  logic                            nout_valid,
  output logic                            intr
);
  localparam int CNT_W = $clog2(NUM_OUT+1);

  wr_state_t wr_state, wr_state_next;
  rd_state_t rd_state, rd_state_next;
  logic      wr_hs, rd_hs;
  logic [4:0] wr_off, rd_off;
  logic [31:0] result_reg;
  logic [C_S_AXI_DATA_WIDTH-1:0] status, rd_value;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_empty;

  // Write strobes are ignored: every register write is a full-word write.
  logic unused_wstrb;
  assign unused_wstrb = ^s_axi_wstrb;

  assign wr_off = word_offset(s_axi_awaddr[4:0]);
  assign rd_off = word_offset(s_axi_araddr[4:0]);

  assign s_axi_awready = wr_hs;
  assign s_axi_wready  = wr_hs;
  assign s_axi_bvalid  = (wr_state == WR_RESP);
  assign s_axi_bresp   = RESP_OKAY;
  assign s_axi_arready = rd_hs;
  assign s_axi_rvalid  = (rd_state == RD_DATA);
  assign s_axi_rresp   = RESP_OKAY;

  // FSM state registers for both channels.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wr_state <= WR_IDLE;
      rd_state <= RD_IDLE;
    end else begin
      wr_state <= wr_state_next;
      rd_state <= rd_state_next;
    end
  end

  // Write channel: accept address+data together, then hold the response.
  always_comb begin
    wr_state_next = wr_state;
    wr_hs         = 1'b0;
    case (wr_state)
      WR_IDLE: if (s_axi_awvalid && s_axi_wvalid) begin
        wr_hs         = 1'b1;
        wr_state_next = WR_RESP;
      end
      WR_RESP: if (s_axi_bready) wr_state_next = WR_IDLE;
      default: wr_state_next = WR_IDLE;
    endcase
  end

  // Read channel: accept the address, then hold data until taken.
  always_comb begin
    rd_state_next = rd_state;
    rd_hs         = 1'b0;
    case (rd_state)
      RD_IDLE: if (s_axi_arvalid) begin
        rd_hs         = 1'b1;
        rd_state_next = RD_DATA;
      end
      RD_DATA: if (s_axi_rready) rd_state_next = RD_IDLE;
      default: rd_state_next = RD_IDLE;
    endcase
  end

  // Configuration registers and one-cycle load strobes.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      weight_value  <= '0;
      weight_valid  <= 1'b0;
      bias_value    <= '0;
      bias_valid    <= 1'b0;
      layer_number  <= '0;
      neuron_number <= '0;
      soft_reset    <= 1'b1;
    end else begin
      weight_valid <= 1'b0;
      bias_valid   <= 1'b0;
      if (wr_hs) begin
        case (wr_off)
          REG_WEIGHT: begin
            weight_value <= s_axi_wdata[DATA_WIDTH-1:0];
            weight_valid <= 1'b1;
          end
          REG_BIAS: begin
            bias_value <= s_axi_wdata[DATA_WIDTH-1:0];
            bias_valid <= 1'b1;
          end
          REG_LAYER:   layer_number  <= s_axi_wdata[31:0];
          REG_NEURON:  neuron_number <= s_axi_wdata[31:0];
          REG_SOFTRST: soft_reset    <= s_axi_wdata[0];
          default: ;
        endcase
      end
    end
  end

  // Result capture; a new result wins over a clearing read of the result.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      result_reg <= '0;
      intr       <= 1'b0;
    end else if (result_valid) begin
      result_reg <= result_data;
      intr       <= 1'b1;
    end else if (rd_hs && rd_off == REG_RESULT) begin
      intr <= 1'b0;
    end
  end

`ifdef ZYNET_OUT_READBACK_EN
  zynet_out_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (NUM_OUT)
  ) u_out_fifo (
    .clk   (s_axi_aclk),
    .rst_n (s_axi_aresetn),
    .clr   (soft_reset),
    .push  (nout_valid && !soft_reset),
    .pop   (rd_hs && rd_off == REG_NOUT),
    .din   (nout_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  ()
  );
`else
  logic unused_nout;
  assign unused_nout = ^{nout_data, nout_valid};
  assign fifo_dout   = '0;
  assign fifo_count  = '0;
  assign fifo_empty  = 1'b0;
`endif

  // Status word and read-data selection.
  always_comb begin
    status = '0;
    status[STAT_INTR] = intr;
`ifdef ZYNET_OUT_READBACK_EN
    status[STAT_EMPTY] = fifo_empty;
    status[STAT_CNT_LSB +: 4] = 4'(fifo_count);
`endif
    rd_value = '0;
    case (rd_off)
      REG_RESULT:  rd_value = result_reg;
      REG_LAYER:   rd_value = layer_number;
      REG_NEURON:  rd_value = neuron_number;
      REG_NOUT:    if (!fifo_empty) rd_value[DATA_WIDTH-1:0] = fifo_dout;
      REG_STATUS:  rd_value = status;
      REG_SOFTRST: rd_value[0] = soft_reset;
      default: ;
    endcase
  end

  // Read data is captured at the address handshake and held until taken.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) s_axi_rdata <= '0;
    else if (rd_hs)     s_axi_rdata <= rd_value;
  end

endmodule

// File: tb/tb_zynet_axil_regs.sv
// Self-checking bench for zynet_axil_regs: a register-level model updated
// at each transaction, a per-cycle compare process, and literal checks.
// Readback-buffer checks follow ZYNET_OUT_READBACK_EN.
module tb_zynet_axil_regs;
  localparam int DW = 16;
  localparam int NOUT = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;
  logic [DW-1:0] weight_value, bias_value, nout_data;
  logic        weight_valid, bias_valid, soft_reset, result_valid, nout_valid, intr;
  logic [31:0] layer_number, neuron_number, result_data;

  zynet_axil_regs dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .weight_value(weight_value), .weight_valid(weight_valid),
    .bias_value(bias_value), .bias_valid(bias_valid),
    .layer_number(layer_number), .neuron_number(neuron_number), .soft_reset(soft_reset),
    .result_data(result_data), .result_valid(result_valid),
    .nout_data(nout_data), .nout_valid(nout_valid), .intr(intr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  int w_pulses = 0;
  int b_pulses = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---- behavioural model of the register file ----
  logic [DW-1:0] m_wv, m_bv;
  int            m_w_cyc, m_b_cyc;
  logic [31:0]   m_layer, m_neuron, m_result;
  logic          m_srst, m_intr;
  logic [DW-1:0] m_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wv = '0; m_bv = '0; m_w_cyc = -1; m_b_cyc = -1;
    m_layer = '0; m_neuron = '0; m_result = '0;
    m_srst = 1'b1; m_intr = 1'b0;
    m_q.delete();
  endtask

  task automatic model_write(input logic [4:0] a, input logic [31:0] d);
    case ({a[4:2], 2'b00})
      5'd0:  begin m_wv = d[DW-1:0]; m_w_cyc = cyc; end
      5'd4:  begin m_bv = d[DW-1:0]; m_b_cyc = cyc; end
      5'd12: m_layer = d;
      5'd16: m_neuron = d;
      5'd28: begin m_srst = d[0]; if (d[0]) m_q.delete(); end
      default: ;
    endcase
  endtask

  task automatic model_read(input logic [4:0] a, output logic [31:0] v);
    v = '0;
    case ({a[4:2], 2'b00})
      5'd8:  begin v = m_result; m_intr = 1'b0; end
      5'd12: v = m_layer;
      5'd16: v = m_neuron;
      5'd20: begin
`ifdef ZYNET_OUT_READBACK_EN
        if (m_q.size() > 0) v = {16'd0, m_q.pop_front()};
`endif
      end
      5'd24: begin
        v[0] = m_intr;
`ifdef ZYNET_OUT_READBACK_EN
        v[1] = (m_q.size() == 0);
        v[7:4] = 4'(m_q.size());
`endif
      end
      5'd28: v = {31'd0, m_srst};
      default: ;
    endcase
  endtask

  // Per-cycle comparison of the registered outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("weight_valid", 32'(weight_valid), (cyc == m_w_cyc) ? 32'd1 : 32'd0);
      check("bias_valid", 32'(bias_valid), (cyc == m_b_cyc) ? 32'd1 : 32'd0);
      check("weight_value", 32'(weight_value), 32'(m_wv));
      check("bias_value", 32'(bias_value), 32'(m_bv));
      check("layer_number", layer_number, m_layer);
      check("neuron_number", neuron_number, m_neuron);
      check("soft_reset", 32'(soft_reset), 32'(m_srst));
      check("intr", 32'(intr), 32'(m_intr));
      if (weight_valid === 1'b1) w_pulses++;
      if (bias_valid === 1'b1) b_pulses++;
    end
  end

  // ---- bus tasks: entered and left at posedge+1 ----
  task automatic axi_write(input logic [4:0] a, input logic [31:0] d);
    int n = 0;
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    while (!(awready && wready) && n < 8) begin @(negedge clk); n++; end
    if (!(awready && wready)) begin
      check("aw_timeout", 32'(awready), 32'd1);
      awvalid = 1'b0; wvalid = 1'b0;
      @(posedge clk); #1;
      return;
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    model_write(a, d);
    @(negedge clk);
    check("bvalid", 32'(bvalid), 32'd1);
    check("bresp", 32'(bresp), 32'd0);
    @(posedge clk); #1;
    $display("WR addr=%0d data=0x%08h", a, d);
  endtask

  task automatic axi_read(input logic [4:0] a, input int hold, output logic [31:0] got);
    logic [31:0] exp;
    int n = 0;
    araddr = a; arvalid = 1'b1; rready = (hold == 0);
    @(negedge clk);
    while (!arready && n < 8) begin @(negedge clk); n++; end
    if (!arready) begin
      check("ar_timeout", 32'(arready), 32'd1);
      arvalid = 1'b0; rready = 1'b1; got = '0;
      @(posedge clk); #1;
      return;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    model_read(a, exp);
    @(negedge clk);
    check("rvalid", 32'(rvalid), 32'd1);
    check("rdata", rdata, exp);
    check("rresp", 32'(rresp), 32'd0);
    got = rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (i == hold - 1) rready = 1'b1;
      @(negedge clk);
      check("rvalid_hold", 32'(rvalid), 32'd1);
      check("rdata_hold", rdata, exp);
    end
    @(posedge clk); #1;
    rready = 1'b1;
    $display("RD addr=%0d data=0x%08h exp=0x%08h", a, got, exp);
  endtask

  task automatic pulse_result(input logic [31:0] d);
    result_data = d; result_valid = 1'b1;
    @(posedge clk); #1;
    result_valid = 1'b0;
    m_result = d; m_intr = 1'b1;
    $display("RESULT data=%0d", d);
  endtask

  task automatic push_nout(input logic [DW-1:0] d);
    nout_data = d; nout_valid = 1'b1;
    @(posedge clk); #1;
    nout_valid = 1'b0;
`ifdef ZYNET_OUT_READBACK_EN
    if (!m_srst && m_q.size() < NOUT) m_q.push_back(d);
`endif
    $display("NOUT push 0x%04h", d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    rst_n = 1'b0;
    awaddr = '0; wdata = '0; wstrb = 4'hF; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b1;
    result_data = '0; result_valid = 1'b0; nout_data = '0; nout_valid = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_soft_reset", 32'(soft_reset), 32'd1);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);

    // soft reset register
    axi_read(5'd28, 0, got);  check("rd28_after_reset", got, 32'd1);
    axi_write(5'd28, 32'd0);  check("soft_reset_clear", 32'(soft_reset), 32'd0);
    axi_read(5'd28, 0, got);  check("rd28_cleared", got, 32'd0);

    // layer/neuron select and weight strobes
    axi_write(5'd12, 32'd1);
    axi_write(5'd16, 32'd5);
    axi_write(5'd0, 32'h0000_0001);
    axi_write(5'd0, 32'h0000_8000);
    axi_write(5'd0, 32'h0000_FFFF);
    check("weight_pulses", 32'(w_pulses), 32'd3);
    check("weight_last", 32'(weight_value), 32'h0000_FFFF);
    check("layer_lit", layer_number, 32'd1);
    check("neuron_lit", neuron_number, 32'd5);
    axi_read(5'd12, 0, got);  check("rd12", got, 32'd1);
    axi_read(5'd16, 2, got);  check("rd16_held", got, 32'd5);

    // bias strobe; weight unaffected
    axi_write(5'd4, 32'h0000_1234);
    check("bias_pulses", 32'(b_pulses), 32'd1);
    check("bias_lit", 32'(bias_value), 32'h0000_1234);
    check("weight_pulses_after_bias", 32'(w_pulses), 32'd3);

    // writes to read-only / write-only reads ignored
    axi_write(5'd24, 32'hFFFF_FFFF);
    axi_write(5'd8, 32'hDEAD_BEEF);
    axi_read(5'd0, 0, got);   check("rd0_zero", got, 32'd0);

    // result capture and interrupt
    pulse_result(32'd7);
    @(negedge clk); check("intr_rise", 32'(intr), 32'd1);
    @(posedge clk); #1;
    axi_read(5'd24, 0, got);  check("status_intr", 32'(got[0]), 32'd1);
    axi_read(5'd8, 0, got);   check("rd8_result", got, 32'd7);
    check("intr_cleared", 32'(intr), 32'd0);

    // readback buffer
    for (int i = 0; i < NOUT; i++) push_nout(DW'(16'h0100 + i));
    axi_read(5'd24, 0, got);
`ifdef ZYNET_OUT_READBACK_EN
    check("status_count10", 32'(got[7:4]), 32'd10);
    check("status_not_empty", 32'(got[1]), 32'd0);
    for (int i = 0; i < NOUT; i++) begin
      axi_read(5'd20, 0, got);
      check("pop_order", got, 32'h0100 + 32'(i));
    end
    axi_read(5'd20, 0, got);  check("pop_empty", got, 32'd0);
    axi_read(5'd24, 0, got);  check("status_empty", 32'(got[1]), 32'd1);
    push_nout(16'hAAAA);
    push_nout(16'hBBBB);
    axi_write(5'd28, 32'd1);
    axi_write(5'd28, 32'd0);
    axi_read(5'd24, 0, got);  check("flush_empty", got[7:0], 32'h02);
`else
    check("status_no_buffer", got, 32'd0);
    axi_read(5'd20, 0, got);  check("rd20_no_buffer", got, 32'd0);
`endif

    // response held while bready low; second write stalls
    bready = 1'b0;
    awaddr = 5'd12; wdata = 32'd2; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk); check("aw_accept", 32'(awready && wready), 32'd1);
    @(posedge clk); #1;
    model_write(5'd12, 32'd2);
    awaddr = 5'd16; wdata = 32'd9;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bvalid_held", 32'(bvalid), 32'd1);
      check("aw_blocked", 32'(awready || wready), 32'd0);
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(negedge clk); check("bvalid_before_ready", 32'(bvalid), 32'd1);
    @(posedge clk); #1;
    @(negedge clk); check("aw_second_accept", 32'(awready && wready), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    model_write(5'd16, 32'd9);
    @(negedge clk); check("bvalid_second", 32'(bvalid), 32'd1);
    @(posedge clk); #1;
    $display("WR stalled pair layer=2 neuron=9");

    // reset asserted mid-read
    araddr = 5'd12; arvalid = 1'b1; rready = 1'b0;
    @(negedge clk); check("ar_accept", 32'(arready), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk); check("rvalid_pending", 32'(rvalid), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("abort_rvalid", 32'(rvalid), 32'd0);
    check("abort_layer", layer_number, 32'd0);
    check("abort_soft_reset", 32'(soft_reset), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1; rready = 1'b1;
    axi_read(5'd12, 0, got);  check("rd12_after_reset", got, 32'd0);
    axi_read(5'd28, 0, got);  check("rd28_after_abort", got, 32'd1);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
